ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: the other direction of the existing keyboard receive path.
//  Sends one command byte to the keyboard (LED set 0xED, reset 0xFF, ...) and reports the device ACK.
//  Sits beside the PS/2 receiver in the apple1 core on clk25; the board top maps *_oe onto open-drain pins.
// PARAMETERS
//  INHIBIT_CYCLES  2500    clk25 cycles PS2 clock is held low before request (100 us @ 25 MHz)
//  TIMEOUT_CYCLES  375000  max clk25 cycles between clock release / falling edges before abort (15 ms)
// PORTS
//  clk25       in   1  system clock, 25 MHz
//  rst         in   1  synchronous reset, active-high
//  tx_data     in   8  command byte, sampled on accept
//  tx_valid    in   1  request to send tx_data
//  tx_ready    out  1  1 = idle, accepts tx_valid this cycle
//  ps2_clk_in  in   1  raw PS2 clock pin level (asynchronous)
//  ps2_din_in  in   1  raw PS2 data pin level (asynchronous)
//  ps2_clk_oe  out  1  1 = drive PS2 clock low, 0 = release (pull-up)
//  ps2_dat_oe  out  1  1 = drive PS2 data low, 0 = release
//  rx_inhibit  out  1  1 while busy; receiver ignores bus traffic
//  done        out  1  one-cycle pulse at end of every accepted frame (success, NACK or timeout)
//  ack_ok      out  1  valid with done: 1 = device drove ACK low
//  err         out  1  valid with done: 1 = timeout abort
// BEHAVIOUR
//  Reset: state IDLE; ps2_clk_oe=0, ps2_dat_oe=0, done=0, ack_ok=0, err=0; tx_ready=1 on first post-reset cycle.
//  Inputs: 2-FF synchronisers on clk/data, plus one history reg; fall = hist & ~clk_s (3-cycle latency).
//  tx_ready = (state==IDLE) combinational; rx_inhibit = ~tx_ready.
//  Accept: tx_valid & tx_ready -> latch tx_data, par = ~^tx_data (odd parity), bit count=0, enter INHIBIT.
//  tx_valid while busy is ignored, not queued; latched byte cannot change mid-frame.
//  INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles; dat_oe=1 asserted in the last of them (start bit).
//  REQ: clk_oe=0, dat_oe=1; timeout counter cleared; wait for fall.
//  DATA: fall n (n=1..8) -> dat_oe = ~tx_data[n-1] (LSB first, registered next cycle).
//  PARITY: fall 9 -> dat_oe = ~par.  STOP: fall 10 -> dat_oe=0 (release, stop=1).
//  ACK: fall 11 -> capture ack_bit = data_s (0 = ACK). WAIT_IDLE: until clk_s=1 & data_s=1.
//  End: from WAIT_IDLE with bus idle -> done=1, ack_ok=~ack_bit, err=0 for one cycle; -> IDLE.
//  Timeout: counter (19 b) cleared on entry to REQ and on every fall; increments in REQ..WAIT_IDLE;
//   at TIMEOUT_CYCLES -> both oe=0, done=1, err=1, ack_ok=0 same cycle, -> IDLE.
//  done/ack_ok/err are registered; ack_ok/err return to 0 the cycle after done.
//  Falls seen in IDLE/INHIBIT ignored. No glitch filter beyond synchroniser.
//  Reset mid-frame: next edge both oe=0, state IDLE, no done pulse.
// TESTING
//  Device model: clock period 80 us (2000 clk25), samples data on rising edge, ACK by pulling data low at edge 11.
//  T1 send 0xED -> clk_oe high exactly 2500 cycles; sampled bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done, ack_ok=1, err=0.
//  T2 send 0x07 -> bits 1,1,1,0,0,0,0,0, parity 0; send 0xFF -> parity 1; both ack_ok=1.
//  T3 model leaves data high at edge 11 -> done=1, ack_ok=0, err=0, tx_ready=1 next cycle.
//  T4 TIMEOUT_CYCLES=1000, model never clocks -> done=1, err=1 exactly 1000 cycles after REQ entry; both oe=0.
//  T5 rst pulsed after fall 4 of 0xA5 -> next cycle both oe=0, tx_ready=1; no done; fresh 0x55 then sends correctly.
//  T6 tx_valid with 0x12 held during 0xED frame -> wire still carries 0xED; 0x12 only sent once re-presented in IDLE.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with device ACK capture and timeout abort
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_din_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);
  localparam logic [18:0] INH_LAST  = 19'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] INH_START = 19'(INHIBIT_CYCLES - 2);
  localparam logic [18:0] TO_LAST   = 19'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, INHIBIT, XFER, WAIT_IDLE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  clk_sync_q;
  logic [1:0]  dat_sync_q;
  logic [18:0] cnt_q, cnt_d;
  logic [8:0]  sh_q, sh_d;
  logic [3:0]  n_q, n_d;
  logic        ack_q, ack_d, clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic        done_q, done_d, ok_q, ok_d, err_q, err_d;
  logic        clk_s, dat_s, fall;
  assign clk_s      = clk_sync_q[1];
  assign dat_s      = dat_sync_q[1];
  assign fall       = clk_sync_q[2] & ~clk_s;
  assign tx_ready   = state_q == IDLE;
  assign rx_inhibit = ~tx_ready;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign done       = done_q;
  assign ack_ok     = ok_q;
  assign err        = err_q;
  always_ff @(posedge clk25) begin
    clk_sync_q <= rst ? 3'b111 : {clk_sync_q[1:0], ps2_clk_in};
    dat_sync_q <= rst ? 2'b11 : {dat_sync_q[0], ps2_din_in};
  end
  // sh_q holds {parity, data}; shifting in ones makes the tenth fall release data as the stop bit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 19'd1;
    sh_d     = sh_q;
    n_d      = n_q;
    ack_d    = ack_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d  = INHIBIT;
        sh_d     = {~^tx_data, tx_data};
        n_d      = 4'd0;
        cnt_d    = 19'd0;
        clk_oe_d = 1'b1;
      end
      INHIBIT: begin
        dat_oe_d = dat_oe_q | (cnt_q == INH_START);
        if (cnt_q == INH_LAST) begin
          state_d  = XFER;
          cnt_d    = 19'd0;
          clk_oe_d = 1'b0;
        end
      end
      XFER: if (fall) begin
        cnt_d = 19'd0;
        n_d   = n_q + 4'd1;
        if (n_q == 4'd10) begin
          ack_d   = dat_s;
          state_d = WAIT_IDLE;
        end else begin
          dat_oe_d = ~sh_q[0];
          sh_d     = {1'b1, sh_q[8:1]};
        end
      end
      WAIT_IDLE: begin
        if (fall) cnt_d = 19'd0;
        if (clk_s & dat_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ok_d    = ~ack_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // a stalled device wins over a simultaneous bus-idle completion
    if ((state_q == XFER || state_q == WAIT_IDLE) && cnt_q == TO_LAST) begin
      state_d  = IDLE;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      done_d   = 1'b1;
      ok_d     = 1'b0;
      err_d    = 1'b1;
    end
  end
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 19'd0;
      sh_q     <= 9'd0;
      n_q      <= 4'd0;
      ack_q    <= 1'b1;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      n_q      <= n_d;
      ack_q    <= ack_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end
endmodule
